ai_frame_scheduler: RTL and testbench

Frame-level ingress controller between the camera timing interface and the FINN accelerator stream input. It converts camera pixels into an AXI-Stream source with real `tready` backpressure through a small pixel FIFO, and marks start and end of frame on that stream. It starts frames on the vsync rising edge and drops the rest of any frame that overflows the FIFO or ends short. It also keeps frame and drop statistics for the AI pipeline.

---
 rtl/ai_frame_scheduler.sv | 139 +++++++++++++
 tb/tb_ai_frame_scheduler.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ai_frame_scheduler.sv
// Camera-to-AXI-Stream frame ingress: vsync-framed pixel capture into a small FIFO,
// with start/end-of-frame marking, overflow/short-frame drop and frame statistics.
module ai_frame_scheduler #(
    parameter int DEPTH        = 16,
    parameter int FRAME_PIXELS = 921600,
    parameter int CNT_W        = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     in_vsync,
    input  logic                     in_den,
    input  logic [23:0]              cam_data,
    output logic [23:0]              m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tuser,
    output logic                     m_axis_tlast,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     frame_drop,
    output logic [15:0]              frame_cnt,
    output logic [15:0]              drop_cnt,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [CNT_W-1:0] FP      = CNT_W'(FRAME_PIXELS);
    localparam logic [CNT_W-1:0] FP_LAST = CNT_W'(FRAME_PIXELS - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE, S_DROP} state_t;

    state_t            state_q, state_d;
    logic              vs_prev_q;
    logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]     level_q, level_d;
    logic [25:0]       mem_q [DEPTH];
    logic              done_q, done_d, drop_q, drop_d;
    logic [15:0]       frame_cnt_q, drop_cnt_q;

    logic vs_rise, den_ok, full, push, pop;

    assign vs_rise = in_vsync && !vs_prev_q;
    assign den_ok  = in_den && !in_vsync;
    assign full    = (level_q == LW'(DEPTH));
    assign pop     = m_axis_tvalid && m_axis_tready;

    always_comb begin
        state_d   = state_q;
        pix_cnt_d = pix_cnt_q;
        done_d    = 1'b0;
        drop_d    = 1'b0;
        push      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (vs_rise && en) begin
                    state_d   = S_ACTIVE;
                    pix_cnt_d = '0;
                end
            end
            S_ACTIVE: begin
                if (vs_rise) begin
                    // A frame cut short by a new vsync counts as dropped.
                    if (pix_cnt_q != '0 && pix_cnt_q < FP) drop_d = 1'b1;
                    state_d   = en ? S_ACTIVE : S_IDLE;
                    pix_cnt_d = '0;
                end else if (den_ok && full) begin
                    state_d = S_DROP;
                    drop_d  = 1'b1;
                end else if (den_ok && pix_cnt_q < FP) begin
                    push      = 1'b1;
                    pix_cnt_d = pix_cnt_q + CNT_W'(1);
                    if (pix_cnt_q == FP_LAST) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_DONE, S_DROP: begin
                if (vs_rise) begin
                    state_d   = en ? S_ACTIVE : S_IDLE;
                    pix_cnt_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            vs_prev_q   <= 1'b0;
            pix_cnt_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            done_q      <= 1'b0;
            drop_q      <= 1'b0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            vs_prev_q <= in_vsync;
            pix_cnt_q <= pix_cnt_d;
            level_q   <= level_d;
            done_q    <= done_d;
            drop_q    <= drop_d;
            if (done_d) frame_cnt_q <= frame_cnt_q + 16'd1;
            if (drop_d) drop_cnt_q  <= drop_cnt_q + 16'd1;
            if (push) begin
                mem_q[wr_ptr_q] <= {pix_cnt_q == '0, pix_cnt_q == FP_LAST, cam_data};
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    assign m_axis_tvalid = (level_q != '0);
    assign m_axis_tdata  = mem_q[rd_ptr_q][23:0];
    assign m_axis_tlast  = mem_q[rd_ptr_q][24];
    assign m_axis_tuser  = mem_q[rd_ptr_q][25];
    assign busy          = (state_q != S_IDLE) || m_axis_tvalid;
    assign frame_done    = done_q;
    assign frame_drop    = drop_q;
    assign frame_cnt     = frame_cnt_q;
    assign drop_cnt      = drop_cnt_q;
    assign fifo_level    = level_q;
endmodule

// File: tb/tb_ai_frame_scheduler.sv
// Scoreboard bench for ai_frame_scheduler: a frame-level reference model queues expected
// beats and statistics; a negedge monitor compares whatever the DUT presents.
module tb_ai_frame_scheduler;
    localparam int DEPTH = 4;
    localparam int FP    = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0, in_vsync = 1'b0, in_den = 1'b0, tready = 1'b0;
    logic [23:0] cam_data = '0;
    logic [23:0] tdata;
    logic        tvalid, tuser, tlast, busy, frame_done, frame_drop;
    logic [15:0] frame_cnt, drop_cnt;
    logic [2:0]  fifo_level;

    ai_frame_scheduler #(.DEPTH(DEPTH), .FRAME_PIXELS(FP), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .en(en), .in_vsync(in_vsync), .in_den(in_den),
        .cam_data(cam_data), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
        .m_axis_tready(tready), .m_axis_tuser(tuser), .m_axis_tlast(tlast),
        .busy(busy), .frame_done(frame_done), .frame_drop(frame_drop),
        .frame_cnt(frame_cnt), .drop_cnt(drop_cnt), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int beats = 0;
    int tlast_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 = not capturing, 1 = collecting pixels, 2 = frame closed
    logic [25:0] exp_q[$];
    int   m_mode = 0, m_pix = 0, m_n = 0;
    logic m_vs = 1'b0, e_done = 1'b0, e_drop = 1'b0;
    logic [15:0] m_fc = '0, m_dc = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_pix = 0; m_n = 0; m_vs = 1'b0;
            e_done = 1'b0; e_drop = 1'b0; m_fc = '0; m_dc = '0;
            exp_q.delete();
        end else begin
            automatic logic rise = in_vsync && !m_vs;
            automatic int   pops = (m_n > 0 && tready) ? 1 : 0;
            automatic int   acc  = 0;
            m_vs   = in_vsync;
            e_done = 1'b0;
            e_drop = 1'b0;
            if (rise) begin
                if (m_mode == 1 && m_pix > 0) begin e_drop = 1'b1; m_dc++; end
                m_mode = en ? 1 : 0;
                m_pix  = 0;
            end else if (m_mode == 1 && in_den && !in_vsync) begin
                if (m_n == DEPTH) begin
                    e_drop = 1'b1; m_dc++; m_mode = 2;
                end else begin
                    exp_q.push_back({m_pix == 0, m_pix == FP - 1, cam_data});
                    acc = 1;
                    m_pix++;
                    if (m_pix == FP) begin e_done = 1'b1; m_fc++; m_mode = 2; end
                end
            end
            m_n = m_n + acc - pops;
        end
    end

    always @(negedge clk) begin
        chk("tvalid", 32'(tvalid), 32'(m_n != 0));
        chk("fifo_level", 32'(fifo_level), 32'(m_n));
        chk("frame_done", 32'(frame_done), 32'(e_done));
        chk("frame_drop", 32'(frame_drop), 32'(e_drop));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_fc));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_dc));
        chk("busy", 32'(busy), 32'(m_mode != 0 || m_n != 0));
        if (tvalid && tready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 32'(1), 32'(0));
            end else begin
                automatic logic [25:0] b = exp_q.pop_front();
                chk("beat", 32'({tuser, tlast, tdata}), 32'(b));
                beats++;
                if (tlast) tlast_seen++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vsync();
        in_vsync = 1'b1; in_den = 1'($urandom); tick();
        in_vsync = 1'b0; in_den = 1'b0; tick();
    endtask

    task automatic pixel(input logic [23:0] d);
        in_den = 1'b1; cam_data = d; tick();
        in_den = 1'b0;
    endtask

    task automatic idle(input int n);
        in_den = 1'b0;
        repeat (n) tick();
    endtask

    task automatic drain();
        int budget = 0;
        tready = 1'b1;
        in_den = 1'b0;
        while ((fifo_level != 0 || m_n != 0) && budget < 100) begin
            tick();
            budget++;
        end
        if (budget >= 100) chk("drain_timeout", 32'(1), 32'(0));
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1; in_den = 1'b0; in_vsync = 1'b0;
        #1;
        chk("rst_outputs", 32'({tvalid, tuser, tlast, busy, frame_done, frame_drop}), 32'(0));
        chk("rst_tdata", 32'(tdata), 32'(0));
        chk("rst_counts", {frame_cnt, drop_cnt}, 32'(0));
        chk("rst_level", 32'(fifo_level), 32'(0));
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int b0, t0;
        tick();
        do_reset();

        // nominal frame
        en = 1'b1; tready = 1'b1;
        vsync();
        for (int i = 1; i <= FP; i++) pixel(24'(i));
        drain();
        chk("nom_beats", 32'(beats), 32'(8));
        chk("nom_tlast", 32'(tlast_seen), 32'(1));
        chk("nom_frame_cnt", 32'(frame_cnt), 32'(1));
        chk("nom_drop_cnt", 32'(drop_cnt), 32'(0));

        // overflow under backpressure
        do_reset();
        tready = 1'b0;
        vsync();
        for (int i = 1; i <= 4; i++) pixel(24'(16 + i));
        chk("ovf_level", 32'(fifo_level), 32'(4));
        pixel(24'h21);
        chk("ovf_drop_pulse", 32'(frame_drop), 32'(1));
        pixel(24'h22);
        chk("ovf_drop_cnt", 32'(drop_cnt), 32'(1));
        b0 = beats; t0 = tlast_seen;
        drain();
        chk("ovf_drain_beats", 32'(beats - b0), 32'(4));
        chk("ovf_no_tlast", 32'(tlast_seen - t0), 32'(0));

        // short frame followed by a full one
        do_reset();
        vsync();
        for (int i = 1; i <= 5; i++) pixel(24'(32 + i));
        vsync();
        for (int i = 1; i <= FP; i++) pixel(24'(48 + i));
        drain();
        chk("short_drop_cnt", 32'(drop_cnt), 32'(1));
        chk("short_frame_cnt", 32'(frame_cnt), 32'(1));

        // en control
        do_reset();
        en = 1'b0;
        vsync();
        b0 = beats;
        for (int i = 1; i <= FP; i++) pixel(24'(64 + i));
        idle(2);
        chk("en0_no_beats", 32'(beats - b0), 32'(0));
        chk("en0_idle", 32'(busy), 32'(0));
        en = 1'b1;
        vsync();
        for (int i = 1; i <= 3; i++) pixel(24'(80 + i));
        en = 1'b0;
        for (int i = 4; i <= FP; i++) pixel(24'(80 + i));
        drain();
        chk("en_mid_frame_cnt", 32'(frame_cnt), 32'(1));
        b0 = beats;
        vsync();
        for (int i = 1; i <= FP; i++) pixel(24'(96 + i));
        idle(2);
        chk("en_next_ignored", 32'(beats - b0), 32'(0));
        chk("en_next_frame_cnt", 32'(frame_cnt), 32'(1));

        // push attempt at full while a pop happens
        do_reset();
        en = 1'b1; tready = 1'b0;
        vsync();
        for (int i = 1; i <= 4; i++) pixel(24'(112 + i));
        tready = 1'b1;
        pixel(24'h75);
        chk("full_pp_drop", 32'(frame_drop), 32'(1));
        chk("full_pp_level", 32'(fifo_level), 32'(3));
        drain();

        // reset mid-frame
        do_reset();
        tready = 1'b0;
        vsync();
        for (int i = 1; i <= 3; i++) pixel(24'(128 + i));
        do_reset();
        tready = 1'b1;
        b0 = beats;
        for (int i = 1; i <= 4; i++) pixel(24'(144 + i));
        idle(2);
        chk("rst_mid_no_beats", 32'(beats - b0), 32'(0));
        chk("rst_mid_level", 32'(fifo_level), 32'(0));

        // randomized traffic
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            en       = ($urandom % 8) != 0;
            in_vsync = ($urandom % 20) == 0;
            in_den   = ($urandom % 4) != 0;
            tready   = ($urandom % 3) != 0;
            cam_data = 24'($urandom);
            tick();
        end
        in_vsync = 1'b0;
        drain();
        chk("rand_queue_empty", 32'(exp_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
